// File: rtl/riscv_wb.sv
// Writeback stage with integer register file, bypassing read ports and a
// per-register pending scoreboard that stalls decode on RAW/WAW hazards.
module riscv_wb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      mem_wb_rdy,
  output logic                      mem_wb_ack,
  input  logic                      mem_wb_we,
  input  logic [$clog2(NREGS)-1:0]  mem_wb_rd,
  input  logic [XLEN-1:0]           mem_wb_data,
  input  logic                      wb_hold,
  input  logic [$clog2(NREGS)-1:0]  id_rs1_addr,
  input  logic [$clog2(NREGS)-1:0]  id_rs2_addr,
  output logic [XLEN-1:0]           id_rs1_data,
  output logic [XLEN-1:0]           id_rs2_data,
  input  logic                      id_issue_vld,
  input  logic                      id_issue_we,
  input  logic [$clog2(NREGS)-1:0]  id_issue_rd,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  output logic                      id_stall,
  output logic [NREGS-1:0]          wb_busy
);
  localparam int AW = $clog2(NREGS);

  logic             wb_vld_q,  wb_vld_d;
  logic             wb_we_q,   wb_we_d;
  logic [AW-1:0]    wb_rd_q,   wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [XLEN-1:0]  rf_q [NREGS];
  logic [XLEN-1:0]  rf_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic wb_wr, commit, xfer, issue_set;
  logic raw1, raw2, waw;

  // Handshake: a transfer happens on any edge where mem_wb_rdy && mem_wb_ack.
  // The writeback register drains every cycle, so only wb_hold withholds ack.
  assign mem_wb_ack = !wb_hold;
  assign xfer       = mem_wb_rdy && mem_wb_ack;
  assign wb_wr      = wb_vld_q && wb_we_q;
  assign commit     = wb_wr && (wb_rd_q != '0);

  always_comb begin
    wb_vld_d  = xfer;
    wb_we_d   = wb_we_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (xfer) begin
      wb_we_d   = mem_wb_we;
      wb_rd_d   = mem_wb_rd;
      wb_data_d = mem_wb_data;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (commit) rf_d[wb_rd_q] = wb_data_q;
  end

  // Read ports: x0 is hardwired, then bypass from the writeback register.
  always_comb begin
    id_rs1_data = rf_q[id_rs1_addr];
    if (wb_wr && wb_rd_q == id_rs1_addr) id_rs1_data = wb_data_q;
    if (id_rs1_addr == '0) id_rs1_data = '0;
    id_rs2_data = rf_q[id_rs2_addr];
    if (wb_wr && wb_rd_q == id_rs2_addr) id_rs2_data = wb_data_q;
    if (id_rs2_addr == '0) id_rs2_data = '0;
  end

  // A pending register whose result sits in the writeback register is
  // already visible through the bypass, so it does not stall.
  always_comb begin
    raw1     = id_rs1_used && busy_q[id_rs1_addr] && !(wb_wr && wb_rd_q == id_rs1_addr);
    raw2     = id_rs2_used && busy_q[id_rs2_addr] && !(wb_wr && wb_rd_q == id_rs2_addr);
    waw      = id_issue_we && (id_issue_rd != '0) && busy_q[id_issue_rd]
               && !(wb_wr && wb_rd_q == id_issue_rd);
    id_stall = id_issue_vld && (raw1 || raw2 || waw);
  end

  assign issue_set = id_issue_vld && !id_stall && id_issue_we && (id_issue_rd != '0);

  // Set is applied after clear so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (commit)    busy_d[wb_rd_q]     = 1'b0;
    if (issue_set) busy_d[id_issue_rd] = 1'b1;
  end

  assign wb_busy = busy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_vld_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      wb_vld_q  <= wb_vld_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
    end
  end
endmodule
